// File: rtl/digital_tube_scan.sv
// digital_tube_scan: time-multiplexed seven-segment driver for DIGITS hex digits
// sharing one segment bus. One digit per slot, one dead-time cycle at every slot
// change, frame-synchronous value loading, leading-zero blanking, per-digit blink
// and decimal points. All outputs are registered from the internal scan state.
module digital_tube_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number_BCD,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} blink_phase_e;

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Scan state
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_flag_q, pend_flag_d;
  logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
  blink_phase_e        phase_q, phase_d;
  logic                wrap_q, wrap_d;

  // Registered outputs
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end;
  logic                frame_end;

  // Next-state: prescaler, digit index, frame-synchronous load and blink phase.
  always_comb begin
    // NOTE: every _d signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
    wrap_d    = frame_end;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load) begin
      pending_d   = number_BCD;
      pend_flag_d = 1'b1;
    end

    // A load in the wrap cycle itself wins over an older pending value.
    if (frame_end) begin
      if (load) begin
        shadow_d = number_BCD;
      end else if (pend_flag_q) begin
        shadow_d = pending_q;
      end
      pend_flag_d = 1'b0;

      if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end

  // Output pattern for the digit currently addressed by idx_q.
  always_comb begin
    logic             all_zero;
    logic [3:0]       nib;
    logic             lz_hit;
    logic             dp_bit;
    logic             blink_bit;
    logic [DIGITS-1:0] onehot;
    logic [7:0]       pat;

    nib       = 4'h0;
    lz_hit    = 1'b0;
    dp_bit    = 1'b0;
    blink_bit = 1'b0;
    onehot    = '0;
    all_zero  = 1'b1;

    // Walk from the most significant digit down so all_zero means "this and every higher digit is 0".
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (shadow_q[i*4 +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib       = shadow_q[i*4 +: 4];
        lz_hit    = all_zero && (i != 0);
        dp_bit    = dp_en[i];
        blink_bit = blink_mask[i];
        onehot[i] = 1'b1;
      end
    end

    pat = {dp_bit, seg_decode(nib)};
    if (blank_lz && lz_hit) begin
      pat[6:0] = 7'h00;
    end
    if (blink_bit && (phase_q == PH_HIDDEN)) begin
      pat = 8'h00;
    end

    seg_d = SEG_ACTIVE_LOW ? ~pat : pat;

    // The cnt=0 cycle of every slot is dead time: no digit enabled while segments settle.
    if (cnt_q == '0) begin
      onehot = '0;
    end
    dig_d = DIG_ACTIVE_LOW ? ~onehot : onehot;

    // Delayed one cycle so the pulse lines up with the new frame's first pattern on seg_out.
    frame_done_d = wrap_q;
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= PH_VISIBLE;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digital_tube_scan.sv
// Directed self-checking bench for digital_tube_scan with DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2, active-low segments and digit selects (16-cycle frame).
module tb_digital_tube_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] number_BCD;
  logic        load;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_frame = 0;

  logic [7:0] cap_seg [4];
  logic [3:0] cap_dig [4];
  logic [7:0] fd_seg;
  logic [3:0] fd_dig;
  logic       fd_after;

  digital_tube_scan #(
    .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .number_BCD(number_BCD), .load(load),
    .dp_en(dp_en), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the frame_done pulse is visible, bounded to four frames.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    cur_frame++;
  endtask

  // Called on the frame_done cycle: capture that cycle and one active cycle of each slot.
  task automatic scan_frame();
    fd_seg = seg_out;
    fd_dig = dig_sel;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 4) tick();
      cap_seg[k] = seg_out;
      cap_dig[k] = dig_sel;
      if (k == 0) fd_after = frame_done;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] es [4];
    logic [3:0] ed [4];
    es = '{e0, e1, e2, e3};
    ed = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_seg%0d", tag, k), {24'd0, cap_seg[k]}, {24'd0, es[k]});
      check($sformatf("%s_dig%0d", tag, k), {28'd0, cap_dig[k]}, {28'd0, ed[k]});
    end
  endtask

  initial begin
    int n;
    logic [7:0] blink_exp [4];

    rst        = 1'b1;
    number_BCD = 16'h0000;
    load       = 1'b0;
    dp_en      = 4'b0000;
    blank_lz   = 1'b0;
    blink_mask = 4'b0000;

    // Reset held for 5 cycles: everything off.
    repeat (5) tick();
    check("rst_seg", {24'd0, seg_out}, 32'hFF);
    check("rst_dig", {28'd0, dig_sel}, 32'hF);
    check("rst_fd",  {31'd0, frame_done}, 32'd0);

    // First slot after release: digit 0 showing 0, dead cycle then 3 active cycles.
    rst = 1'b0;
    tick();
    check("first_dead_seg", {24'd0, seg_out}, 32'hC0);
    check("first_dead_dig", {28'd0, dig_sel}, 32'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("first_act_dig%0d", k), {28'd0, dig_sel}, 32'hE);
    end
    check("first_act_seg", {24'd0, seg_out}, 32'hC0);
    check("first_fd_low", {31'd0, frame_done}, 32'd0);
    tick();
    check("slot1_dead_dig", {28'd0, dig_sel}, 32'hF);

    // Mid-frame load of 1234: display must not change before the frame boundary.
    number_BCD = 16'h1234;
    load       = 1'b1;
    tick();
    load       = 1'b0;
    check("midload_seg_unchanged", {24'd0, seg_out}, 32'hC0);
    check("midload_dig", {28'd0, dig_sel}, 32'hD);
    wait_frame(n);
    check("first_frame_len", n, 32'd11);
    scan_frame();
    check("load_fd_seg", {24'd0, fd_seg}, 32'h99);
    check("load_fd_dig", {28'd0, fd_dig}, 32'hF);
    check("fd_one_cycle", {31'd0, fd_after}, 32'd0);
    check_frame("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // 0070 with leading-zero blanking and dp on digit 1.
    number_BCD = 16'h0070;
    blank_lz   = 1'b1;
    dp_en      = 4'b0010;
    load       = 1'b1;
    tick();
    load       = 1'b0;
    wait_frame(n);
    scan_frame();
    check_frame("lz0070", 8'hC0, 8'h78, 8'hFF, 8'hFF);

    // Blink digit 0 showing 5; frames 3..6 are hidden, visible, visible, hidden.
    number_BCD = 16'h0005;
    blank_lz   = 1'b0;
    dp_en      = 4'b0000;
    blink_mask = 4'b0001;
    load       = 1'b1;
    tick();
    load       = 1'b0;
    blink_exp  = '{8'hFF, 8'h92, 8'h92, 8'hFF};
    for (int f = 0; f < 4; f++) begin
      wait_frame(n);
      scan_frame();
      check($sformatf("blink_f%0d_d0", cur_frame), {24'd0, cap_seg[0]}, {24'd0, blink_exp[f]});
      check($sformatf("blink_f%0d_dig0", cur_frame), {28'd0, cap_dig[0]}, 32'hE);
      check($sformatf("blink_f%0d_d1", cur_frame), {24'd0, cap_seg[1]}, 32'hC0);
    end
    blink_mask = 4'b0000;

    // Pending 1111 then a load of 9999 in the exact wrap cycle: 9999 wins.
    number_BCD = 16'h1111;
    load       = 1'b1;
    tick();
    number_BCD = 16'h9999;
    tick();
    load       = 1'b0;
    wait_frame(n);
    check("wrapload_len", n, 32'd1);
    scan_frame();
    check_frame("wrap9999", 8'h90, 8'h90, 8'h90, 8'h90);
    wait_frame(n);
    scan_frame();
    check_frame("pend_cleared", 8'h90, 8'h90, 8'h90, 8'h90);

    // Pending 4321 then reset during the digit 2 slot: outputs off at once, load discarded.
    wait_frame(n);
    number_BCD = 16'h4321;
    load       = 1'b1;
    tick();
    load       = 1'b0;
    repeat (9) tick();
    check("pre_rst_dig2", {28'd0, dig_sel}, 32'hB);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_seg", {24'd0, seg_out}, 32'hFF);
    check("async_rst_dig", {28'd0, dig_sel}, 32'hF);
    check("async_rst_fd",  {31'd0, frame_done}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    cur_frame = 0;
    tick();
    check("restart_dead_seg", {24'd0, seg_out}, 32'hC0);
    check("restart_dead_dig", {28'd0, dig_sel}, 32'hF);
    tick();
    check("restart_act_dig", {28'd0, dig_sel}, 32'hE);
    wait_frame(n);
    check("restart_frame_len", n, 32'd15);
    scan_frame();
    check_frame("restart_f1", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wait_frame(n);
    scan_frame();
    check_frame("restart_f2", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_tube_scan.md
# digital_tube_scan

Parametrised, time-multiplexed seven-segment display driver for DIGITS BCD/hex digits sharing one segment bus. Scans one digit per slot with per-digit select lines, inserting a one-cycle dead time at each slot change to suppress ghosting. Adds tear-free frame-synchronous value loading, leading-zero blanking, per-digit blink and decimal points. Sits between the counter/datapath logic and the board display pins.

## Interface
- DIGITS, 4: number of digits, 1..8
- SCAN_DIV, 50000: clock cycles per digit slot, ≥2
- BLINK_DIV, 64: frames per blink half-period, ≥1
- SEG_ACTIVE_LOW, 1: 1 = seg_out low-true
- DIG_ACTIVE_LOW, 1: 1 = dig_sel low-true
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- number_BCD  input  4*DIGITS  nibble i = digit i (digit 0 = least significant)
- load  input  1  capture number_BCD for display
- dp_en  input  DIGITS  decimal point enable per digit
- blank_lz  input  1  enable leading-zero blanking
- blink_mask  input  DIGITS  digits that blink
- seg_out  output  8  bit0..6 = segments a..g, bit7 = dp
- dig_sel  output  DIGITS  one-hot digit enable
- frame_done  output  1  one-cycle pulse at end of each full scan

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1; at cnt = SCAN_DIV-1 it wraps and digit index idx advances, DIGITS-1 wraps to 0 (frame boundary).
- Display value held in shadow register (reset 0). load=1 captures number_BCD into pending register and sets pending flag. At the frame-boundary edge: shadow ← number_BCD if load=1 in that cycle, else pending if flag set, else unchanged; flag clears. Values never change mid-frame.
- Decode (active-high a..g): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Leading-zero blanking (blank_lz=1): digit i>0 blanked when it and all higher digits are 0; digit 0 never blanked. Blanked digit: segments a..g off, dp still follows dp_en.
- Blink: phase bit (reset = visible) toggles after every BLINK_DIV completed frames. In hidden phase, digits with blink_mask set have all 8 bits off, dp included. blank_lz, dp_en and blink_mask are sampled live.
- Polarity applied last: seg_out = SEG_ACTIVE_LOW ? ~pattern : pattern; same for dig_sel.

## Timing
- All outputs registered, one cycle after internal state.
- Per slot: cycle with cnt=0 → dig_sel all inactive (dead time), seg_out already carries new digit's pattern; cnt=1..SCAN_DIV-1 → dig_sel active for idx.
- Frame = DIGITS*SCAN_DIV cycles; frame_done high for exactly the one cycle following the edge where idx wraps to 0, coincident with the new shadow value first driving seg_out.
- Reset values: seg_out all off (8'hFF when active-low), dig_sel all inactive, frame_done 0, cnt 0, idx 0, shadow 0, pending flag 0, blink visible.
- Reset mid-scan: outputs go inactive immediately (asynchronous), pending load discarded; after release scan restarts at digit 0, cnt 0.
- First displayed value after reset is 0 until a load is applied at a frame boundary.

## Test plan
Config DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, both active-low (frame = 16 cycles).
- Hold rst 5 cycles, release -> during reset seg_out=8'hFF, dig_sel=4'hF; first slot shows digit 0 = 0: seg_out=8'hC0, dig_sel=4'hF for 1 cycle then 4'hE for 3.
- load=1 with 0x1234 mid-frame -> display unchanged until frame_done; then digit0 seg_out=8'h99 (dig_sel 4'hE), digit3 seg_out=8'hF9 (dig_sel 4'h7).
- load 0x0070, blank_lz=1, dp_en=4'b0010 -> digit3, digit2 seg_out=8'hFF; digit1 seg_out=8'h78; digit0 seg_out=8'hC0.
- blink_mask=4'b0001, value 0x0005 -> digit0 shows 8'h92 for frames 0-1, 8'hFF for frames 2-3, repeating; other digits unaffected.
- load asserted in the exact wrap cycle with 0x9999 while pending 0x1111 -> next frame shows 9999 (seg_out=8'h90 every slot); pending cleared.
- Assert rst during digit2 slot -> same cycle seg_out=8'hFF, dig_sel=4'hF, frame_done=0; after release scan restarts at digit 0 showing 0.
